// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU function codes,
// sequencer states and the opcode-to-instruction-class helpers.
package cpu_ctrl_pkg;

  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpOr   = 5'b00011;
  localparam logic [4:0] OpShr  = 5'b00100;
  localparam logic [4:0] OpShl  = 5'b00101;
  localparam logic [4:0] OpAddi = 5'b01000;
  localparam logic [4:0] OpAndi = 5'b01001;
  localparam logic [4:0] OpOri  = 5'b01010;
  localparam logic [4:0] OpLd   = 5'b01100;
  localparam logic [4:0] OpSt   = 5'b01101;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpDiv  = 5'b10001;
  localparam logic [4:0] OpMfhi = 5'b10010;
  localparam logic [4:0] OpMflo = 5'b10011;
  localparam logic [4:0] OpNop  = 5'b11110;
  localparam logic [4:0] OpHalt = 5'b11111;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluAnd = 4'd2;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluShr = 4'd4;
  localparam logic [3:0] AluShl = 4'd5;
  localparam logic [3:0] AluMul = 4'd6;
  localparam logic [3:0] AluDiv = 4'd7;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  typedef enum logic [3:0] {
    ClsRtype, ClsItype, ClsMulDiv, ClsLoad, ClsStore,
    ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShl: return ClsRtype;
      OpAddi, OpAndi, OpOri:                   return ClsItype;
      OpMul, OpDiv:                            return ClsMulDiv;
      OpLd:                                    return ClsLoad;
      OpSt:                                    return ClsStore;
      OpMfhi:                                  return ClsMfhi;
      OpMflo:                                  return ClsMflo;
      OpNop:                                   return ClsNop;
      OpHalt:                                  return ClsHalt;
      default:                                 return ClsIllegal;
    endcase
  endfunction

  // Address arithmetic for LD/ST falls through to ADD.
  function automatic logic [3:0] alu_func(input logic [4:0] op);
    case (op)
      OpSub:         return AluSub;
      OpAnd, OpAndi: return AluAnd;
      OpOr, OpOri:   return AluOr;
      OpShr:         return AluShr;
      OpShl:         return AluShl;
      OpMul:         return AluMul;
      OpDiv:         return AluDiv;
      default:       return AluAdd;
    endcase
  endfunction

  function automatic logic [2:0] last_step(input op_class_e cls);
    case (cls)
      ClsRtype, ClsItype: return 3'd5;
      ClsMulDiv:          return 3'd6;
      ClsLoad, ClsStore:  return 3'd7;
      default:            return 3'd3;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select with enable; all-zero when disabled.
module reg_select_decoder (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the bus-based 32-bit datapath.
// Step-counted FSM; strobes decode combinationally from state, step and IR.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_done,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        hi_out,
  output logic        lo_out,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        zhigh_out,
  output logic        c_out,
  output logic [3:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        bus_error,
  output logic [3:0]  step
);

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q;
  logic [2:0] step_q;
  logic [7:0] wait_cnt_q;
  logic       halted_q;
  logic       bus_error_q;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  op_class_e  cls;
  logic       in_wait;
  logic       is_last;
  logic       ro_en, ri_en;
  logic [3:0] ro_sel;
  logic       unused_ir;

  // IR is only valid from T3 onward; cls is never consulted before then.
  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign cls       = op_class(opcode);

  assign in_wait = (state_q == StRun) &&
                   ((step_q == 3'd1) ||
                    (cls == ClsLoad  && step_q == 3'd6) ||
                    (cls == ClsStore && step_q == 3'd7));
  assign is_last = (step_q >= 3'd3) && (step_q == last_step(cls));

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q     <= StIdle;
      step_q      <= '0;
      wait_cnt_q  <= '0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run) begin
            state_q <= StRun;
            step_q  <= '0;
          end
        end
        StRun: begin
          if (in_wait && !mem_done) begin
            if (wait_cnt_q == TimeoutLast) begin
              state_q     <= StHalt;
              step_q      <= '0;
              wait_cnt_q  <= '0;
              halted_q    <= 1'b1;
              bus_error_q <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + 8'd1;
            end
          end else begin
            // Leaving any step (or finishing a wait) rearms the counter for the next wait.
            wait_cnt_q <= '0;
            if (is_last) begin
              step_q <= '0;
              if (cls == ClsHalt || cls == ClsIllegal) begin
                state_q  <= StHalt;
                halted_q <= 1'b1;
              end else if (!run) begin
                state_q <= StIdle;
              end
            end else begin
              step_q <= step_q + 3'd1;
            end
          end
        end
        StHalt: begin
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    pc_out    = 1'b0;
    pc_in     = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    hi_out    = 1'b0;
    lo_out    = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    c_out     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_op    = AluAdd;
    ro_en     = 1'b0;
    ro_sel    = rb;
    ri_en     = 1'b0;
    if (state_q == StRun) begin
      case (step_q)
        3'd0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
          inc_pc = 1'b1;
          z_in   = 1'b1;
        end
        3'd1: begin
          zlow_out = 1'b1;
          pc_in    = 1'b1;
          mem_read = 1'b1;
          mdr_in   = mem_done;
        end
        3'd2: begin
          mdr_out = 1'b1;
          ir_in   = 1'b1;
        end
        default: begin
          case (cls)
            ClsRtype, ClsItype, ClsLoad, ClsStore: begin
              case (step_q)
                3'd3: begin
                  ro_en = 1'b1;
                  y_in  = 1'b1;
                end
                3'd4: begin
                  ro_en  = (cls == ClsRtype);
                  ro_sel = rc;
                  c_out  = (cls != ClsRtype);
                  z_in   = 1'b1;
                  alu_op = alu_func(opcode);
                end
                3'd5: begin
                  zlow_out = 1'b1;
                  ri_en    = (cls == ClsRtype) || (cls == ClsItype);
                  mar_in   = (cls == ClsLoad) || (cls == ClsStore);
                end
                3'd6: begin
                  mem_read = (cls == ClsLoad);
                  mdr_in   = (cls == ClsLoad) ? mem_done : (cls == ClsStore);
                  ro_en    = (cls == ClsStore);
                  ro_sel   = ra;
                end
                3'd7: begin
                  mdr_out   = (cls == ClsLoad);
                  ri_en     = (cls == ClsLoad);
                  mem_write = (cls == ClsStore);
                end
                default: begin
                end
              endcase
            end
            ClsMulDiv: begin
              case (step_q)
                3'd3: begin
                  ro_en  = 1'b1;
                  ro_sel = ra;
                  y_in   = 1'b1;
                end
                3'd4: begin
                  ro_en  = 1'b1;
                  z_in   = 1'b1;
                  alu_op = alu_func(opcode);
                end
                3'd5: begin
                  zlow_out = 1'b1;
                  lo_in    = 1'b1;
                end
                3'd6: begin
                  zhigh_out = 1'b1;
                  hi_in     = 1'b1;
                end
                default: begin
                end
              endcase
            end
            ClsMfhi: begin
              hi_out = (step_q == 3'd3);
              ri_en  = (step_q == 3'd3);
            end
            ClsMflo: begin
              lo_out = (step_q == 3'd3);
              ri_en  = (step_q == 3'd3);
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  reg_select_decoder u_out_dec (
    .en_i    (ro_en),
    .sel_i   (ro_sel),
    .onehot_o(reg_out)
  );

  reg_select_decoder u_in_dec (
    .en_i    (ri_en),
    .sel_i   (ra),
    .onehot_o(reg_in)
  );

  assign step      = {1'b0, step_q};
  assign halted    = halted_q;
  assign bus_error = bus_error_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the bus-based 32-bit CPU datapath (R0–R15, HI, LO, IR, MAR, MDR, Y, Z, PC).
- Runs fetch/decode/execute as a step-counted FSM and drives every datapath strobe: register out/in selects, Yin, Zin, MDR/MAR loads, ALU op, and the memory Read/Write handshake.
- Sits between the instruction memory interface and the datapath top level.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_done before flagging bus_error (1..255).

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous, active-low reset
- run  in  1  1 = allow the next fetch; sampled only at the FETCH_T0 boundary
- ir  in  32  IR contents: opcode[31:27], ra[26:23], rb[22:19], rc[18:15], C[18:0]
- mem_done  in  1  memory completion strobe, one cycle
- reg_out  out  16  one-hot R0–R15 bus-drive select
- reg_in  out  16  one-hot R0–R15 load select
- pc_out, pc_in, inc_pc  out  1 each  PC control
- mar_in, mdr_in, mdr_out, ir_in  out  1 each  special-register strobes
- hi_in, lo_in, hi_out, lo_out  out  1 each  HI/LO strobes
- y_in, z_in, zlow_out, zhigh_out, c_out  out  1 each  ALU operand/result strobes; c_out drives sign-extended C onto the bus
- alu_op  out  4  ALU function code
- mem_read, mem_write  out  1 each  memory request, held until mem_done
- halted  out  1  sticky; set on HALT, illegal opcode, or timeout
- bus_error  out  1  sticky; set on memory timeout
- step  out  4  current T-step, for debug

Behaviour:
- Reset (clear=0 at an edge): state IDLE, step=0, wait counter=0, halted=0, bus_error=0.
- In reset and in IDLE/HALT, every strobe, reg_out, reg_in and alu_op is 0.
- Strobes are decoded combinationally from the registered state and ir. Exactly one bus driver is asserted in any cycle.
- IDLE -> FETCH_T0 when run=1. Check run again at each instruction end: run=0 -> IDLE.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, z_in, alu_op=ADD.
  - T1: zlow_out, pc_in, mem_read. Stay in T1 until mem_done; mdr_in=1 only in the mem_done cycle (Mealy).
  - T2: mdr_out, ir_in.
  - T3 onward: execute. Decode uses ir captured at T2.
- R-type (ADD, SUB, AND, OR, SHR, SHL):
  - T3: reg_out[rb], y_in.
  - T4: reg_out[rc], alu_op, z_in.
  - T5: zlow_out, reg_in[ra].
- I-type (ADDI, ANDI, ORI):
  - T3: reg_out[rb], y_in.
  - T4: c_out, alu_op, z_in.
  - T5: zlow_out, reg_in[ra].
- MUL/DIV:
  - T3: reg_out[ra], y_in.
  - T4: reg_out[rb], alu_op, z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in.
- LD:
  - T3–T5: effective address = rb + C into MAR (T5: zlow_out, mar_in).
  - T6: mem_read, wait for mem_done, mdr_in on mem_done.
  - T7: mdr_out, reg_in[ra].
- ST:
  - T3–T5: as LD.
  - T6: reg_out[ra], mdr_in.
  - T7: mem_write, wait for mem_done.
- MFHI/MFLO, T3: hi_out or lo_out, reg_in[ra].
- NOP: return to FETCH_T0 after T2.
- HALT: set halted and enter HALT. HALT exits only via clear.
- Illegal opcode: set halted, enter HALT; no register write.
- Memory wait:
  - Counter clears on entry to any wait step and increments each waiting cycle.
  - Count reaching MEM_TIMEOUT without mem_done -> bus_error=1, halted=1, HALT; mem_read/mem_write drop the next cycle.
  - mem_done in the same cycle as the timeout: done wins.
  - mem_done outside a wait step is ignored.
- clear mid-instruction aborts all strobes at that edge; no partial write completes.
- step = 0..7 within an instruction, 0 in IDLE/HALT.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcodes: ADD 00000, SUB 00001, AND 00010, OR 00011, SHR 00100, SHL 00101, ADDI 01000, ANDI 01001, ORI 01010, LD 01100, ST 01101, MUL 10000, DIV 10001, MFHI 10010, MFLO 10011, NOP 11110, HALT 11111;
  - alu_op codes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHL 5, MUL 6, DIV 7;
  - the state enumeration.
- Sub-module reg_select_decoder: 4-to-16 one-hot decoder with enable, instantiated twice (reg_out, reg_in).

Test Plan:
- Reset: clear=0 for 2 cycles with run=1 -> all outputs 0, step=0; after release, FETCH_T0 shows pc_out=mar_in=inc_pc=z_in=1.
- ADD R5,R2,R4 (ir=0x02920000), mem_done 2 cycles after mem_read:
  - T3: reg_out=0x0004, y_in;
  - T4: reg_out=0x0010, alu_op=0, z_in;
  - T5: reg_in=0x0020, zlow_out;
  - back at FETCH_T0.
- MUL with ra=3, rb=7 -> T5 lo_in+zlow_out, T6 hi_in+zhigh_out, reg_in stays 0 throughout.
- LD, mem_done delayed 10 cycles -> mem_read held 10 cycles, mdr_in high only in the mem_done cycle, next cycle reg_in[ra] with mdr_out.
- ST, mem_done never arrives, MEM_TIMEOUT=8 -> bus_error=halted=1 after 8 wait cycles, mem_write low afterwards, stays halted until clear.
- Opcode 10111 -> halted=1, no reg_in asserted; run=0 at instruction end -> IDLE, no further fetch.
